// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage for the Lab2 4-bit ALU.
// Captures the ALU result and NZCV flags through a valid/ready handshake and
// then holds them for HOLD_CYCLES cycles. During that window new input is
// refused, not queued. The block also keeps sticky flags, counts captures and
// drives an active-low 7-segment digit for the held result.
module alu_result_stage #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     y,
    input  logic                 N,
    input  logic                 Z,
    input  logic                 C,
    input  logic                 V,
    output logic [WIDTH-1:0]     result_q,
    output logic [3:0]           flags_q,
    output logic [3:0]           sticky_q,
    input  logic                 sticky_clr,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic                 out_valid,
    output logic [6:0]           seg
);

    // The timer only has to count down from HOLD_CYCLES-1 to 0.
    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic          capture;
    logic [3:0]    flags_in;
    logic [3:0]    nib;

    // Hex to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign flags_in = {N, Z, C, V};
    assign capture  = in_valid & in_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode: ready only while idle.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold timer: loaded on capture, counts down to zero while holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else if (capture) begin
            timer_q <= TW'(HOLD_CYCLES - 1);
        end else if (state_q == HOLD && timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    // Capture registers: result, flags, capture counter and the valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            flags_q   <= '0;
            op_count  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= capture;
            if (capture) begin
                result_q <= y;
                flags_q  <= flags_in;
                op_count <= op_count + CNT_WIDTH'(1);
            end
        end
    end

    // Sticky flags: a same-cycle clear wipes history before new flags are ORed in.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (capture) begin
            sticky_q <= (sticky_clr ? 4'b0000 : sticky_q) | flags_in;
        end else if (sticky_clr) begin
            sticky_q <= 4'b0000;
        end
    end

    // The display shows only the low nibble of the held result.
    generate
        if (WIDTH >= 4) begin : g_nib_wide
            assign nib = result_q[3:0];
        end else begin : g_nib_narrow
            assign nib = {{(4 - WIDTH){1'b0}}, result_q};
        end
    endgenerate

    assign seg = hex_to_seg(nib);

endmodule
